// File: rtl/score_keeper.sv
// Match-score controller for pong: debounces the two setup buttons, holds the
// winning score, counts points during play and flags the winner.
module score_keeper #(
  parameter int SCORE_W         = 5,
  parameter int MAX_DEFAULT     = 5,
  parameter int MAX_LIMIT       = 31,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         btn_n,
  input  logic               start,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [SCORE_W-1:0] max_score,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         state,
  output logic [1:0]         winner,
  output logic [SCORE_W-1:0] led
);

  typedef enum logic [1:0] {
    ST_SETUP = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] MAX_DEF_V = SCORE_W'(MAX_DEFAULT);
  localparam logic [SCORE_W-1:0] MAX_LIM_V = SCORE_W'(MAX_LIMIT);
  localparam logic [SCORE_W-1:0] ONE_V     = SCORE_W'(1);

  // Button front end: synchroniser, per-bit debounce counter, press detector.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_q, db_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            press_q, press_d;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   max_q, max_d;
  logic [SCORE_W-1:0]   s1_q, s1_d;
  logic [SCORE_W-1:0]   s2_q, s2_d;
  logic [1:0]           win_q, win_d;

  logic                 inc_p, dec_p;
  logic [SCORE_W-1:0]   s1_next, s2_next;
  logic                 hit1, hit2;

  assign inc_p = press_q[0];
  assign dec_p = press_q[1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    press_d = db_q & ~db_d;
  end

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    s1_next = point_p1 ? s1_q + ONE_V : s1_q;
    s2_next = point_p2 ? s2_q + ONE_V : s2_q;
    hit1    = point_p1 && (s1_next == max_q);
    hit2    = point_p2 && (s2_next == max_q);

    unique case (state_q)
      ST_SETUP: begin
        if (start) begin
          state_d = ST_PLAY;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = 2'b00;
        end else if (inc_p && !dec_p && (max_q < MAX_LIM_V)) begin
          max_d = max_q + ONE_V;
        end else if (dec_p && !inc_p && (max_q > ONE_V)) begin
          max_d = max_q - ONE_V;
        end
      end
      ST_PLAY: begin
        s1_d = s1_next;
        s2_d = s2_next;
        if (hit1 || hit2) begin
          state_d = ST_OVER;
          win_d   = {hit2, hit1};
        end
      end
      ST_OVER: begin
        // start takes priority over a simultaneous button press
        if (start || inc_p || dec_p) begin
          state_d = start ? ST_PLAY : ST_SETUP;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = 2'b00;
        end
      end
      default: begin
        state_d = ST_SETUP;
        s1_d    = '0;
        s2_d    = '0;
        win_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      db_q    <= 2'b11;
      cnt_q   <= '0;
      press_q <= 2'b00;
      state_q <= ST_SETUP;
      max_q   <= MAX_DEF_V;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= 2'b00;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      state_q <= state_d;
      max_q   <= max_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_SETUP: led = max_q;
      ST_PLAY:  led = s1_q;
      default:  led = {SCORE_W{1'b1}};
    endcase
  end

  assign max_score = max_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign state     = state_q;
  assign winner    = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus updates an abstract game model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_score_keeper;

  localparam int W    = 5;
  localparam int HOLD = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   btn_n;
  logic         start, point_p1, point_p2;
  logic [W-1:0] max_score, score1, score2, led;
  logic [1:0]   state, winner;

  score_keeper #(
    .SCORE_W(W), .MAX_DEFAULT(5), .MAX_LIMIT(31), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .start(start),
    .point_p1(point_p1), .point_p2(point_p2), .max_score(max_score),
    .score1(score1), .score2(score2), .state(state), .winner(winner), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] mx, s1, s2, ld;
    logic [1:0]   st, win;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Abstract game model: plain integers, 0=setup 1=play 2=over
  int m_max, m_s1, m_s2, m_st, m_win;

  function automatic void m_reset();
    m_max = 5; m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0;
  endfunction

  function automatic void m_press(bit inc, bit dec);
    if (m_st == 0) begin
      if (inc && !dec) m_max = (m_max + 1 > 31) ? 31 : m_max + 1;
      if (dec && !inc) m_max = (m_max - 1 < 1) ? 1 : m_max - 1;
    end else if (m_st == 2) begin
      m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    end
  endfunction

  function automatic void m_cycle(bit s, bit a, bit b);
    if (m_st == 1) begin
      m_s1 += a;
      m_s2 += b;
      if (m_s1 == m_max || m_s2 == m_max) begin
        m_st  = 2;
        m_win = ((m_s2 == m_max) ? 2 : 0) + ((m_s1 == m_max) ? 1 : 0);
      end
    end else if (s) begin
      m_st = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
    end
  endfunction

  task automatic push_exp(string name);
    exp_t e;
    e.name = name;
    e.mx   = W'(m_max);
    e.s1   = W'(m_s1);
    e.s2   = W'(m_s2);
    e.st   = 2'(m_st);
    e.win  = 2'(m_win);
    e.ld   = (m_st == 0) ? W'(m_max) : (m_st == 1) ? W'(m_s1) : W'(31);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({max_score, score1, score2, state, winner, led} !==
          {e.mx, e.s1, e.s2, e.st, e.win, e.ld}) begin
        errors++;
        $display("FAIL %s: got max=%0d s1=%0d s2=%0d st=%b win=%b led=%0d, want max=%0d s1=%0d s2=%0d st=%b win=%b led=%0d",
                 e.name, max_score, score1, score2, state, winner, led,
                 e.mx, e.s1, e.s2, e.st, e.win, e.ld);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string name);
    reset = 1'b1; btn_n = 2'b11; start = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    tick();
    m_reset();
    push_exp(name);
    reset = 1'b0;
  endtask

  task automatic pulse(bit s, bit a, bit b, string name);
    start = s; point_p1 = a; point_p2 = b;
    tick();
    start = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    m_cycle(s, a, b);
    push_exp(name);
  endtask

  task automatic press(bit inc, bit dec, bit bounce, string name);
    logic [1:0] lvl;
    lvl = ~{dec, inc};
    if (bounce) begin
      repeat (3) begin
        btn_n = lvl;   repeat (3) tick();
        btn_n = 2'b11; repeat (3) tick();
      end
    end
    btn_n = lvl;   repeat (HOLD) tick();
    btn_n = 2'b11; repeat (HOLD) tick();
    m_press(inc, dec);
    push_exp(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; btn_n = 2'b11; start = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    #1;

    // reset and idle
    do_reset("t1_reset");
    pulse(0, 0, 0, "t1_idle");

    // bouncy inc press, held 20 cycles: exactly one increment
    repeat (3) begin
      btn_n = 2'b10; repeat (3) tick();
      btn_n = 2'b11; repeat (3) tick();
    end
    push_exp("t2_bounce_only");
    btn_n = 2'b10;
    repeat (4) tick();
    push_exp("t2_not_yet");
    repeat (8) tick();
    m_press(1, 0);
    push_exp("t2_pressed");
    repeat (8) tick();
    push_exp("t2_held");
    btn_n = 2'b11;
    repeat (HOLD) tick();
    push_exp("t2_released");

    // saturation at both ends and simultaneous press
    do_reset("t3_reset");
    repeat (7)  press(0, 1, 0, "t3_dec");
    repeat (40) press(1, 0, 0, "t3_inc");
    press(1, 1, 0, "t3_both");

    // p1 wins at max_score=3, extra points ignored, press in OVER -> SETUP
    do_reset("t4_reset");
    press(0, 1, 0, "t4_dec");
    press(0, 1, 0, "t4_dec");
    pulse(1, 0, 0, "t4_start");
    repeat (3) pulse(0, 1, 0, "t4_p1");
    pulse(0, 1, 0, "t4_p1_ignored");
    pulse(0, 0, 1, "t4_p2_ignored");
    press(1, 0, 0, "t4_press_over");

    // draw at max_score=2
    press(0, 1, 0, "t5_dec");
    pulse(1, 0, 0, "t5_start");
    pulse(0, 1, 0, "t5_p1");
    pulse(0, 0, 1, "t5_p2");
    pulse(0, 1, 1, "t5_both");
    pulse(1, 0, 0, "t5_restart");

    // reset in the middle of play
    pulse(0, 1, 0, "t6_p1");
    do_reset("t6_reset_mid_play");
    pulse(0, 0, 0, "t6_after_reset");

    // randomized mix
    repeat (120) begin
      case ($urandom_range(0, 9))
        0, 1:    press(1, 0, $urandom_range(0, 3) == 0, "rnd_inc");
        2, 3:    press(0, 1, 0, "rnd_dec");
        4:       press(1, 1, 0, "rnd_both");
        5:       pulse(1, 0, 0, "rnd_start");
        6, 7, 8: begin
          k = $urandom_range(1, 3);
          pulse($urandom_range(0, 4) == 0, k[0], k[1], "rnd_point");
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset("rnd_reset");
          else pulse(0, 0, 0, "rnd_idle");
        end
      endcase
    end

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
